// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the next-PC sequencer.
package pc_seq_pkg;

   localparam int DEF_WIDTH     = 16;
   localparam int DEF_RAS_DEPTH = 4;
   localparam int DEF_JMP_BITS  = 9;

   // Next-PC source chosen by the priority encoder.
   typedef enum logic [2:0] {
      NPC_SEQ     = 3'd0,
      NPC_HOLD    = 3'd1,
      NPC_REDIR   = 3'd2,
      NPC_JMP     = 3'd3,
      NPC_CALL    = 3'd4,
      NPC_RET     = 3'd5,
      NPC_CALLRET = 3'd6
   } npc_sel_e;

   // Any non-sequential, non-held source discards the instruction in fetch/decode.
   function automatic logic sel_flushes(input npc_sel_e sel);
      logic res;
      case (sel)
         NPC_REDIR, NPC_JMP, NPC_CALL, NPC_RET, NPC_CALLRET: res = 1'b1;
         NPC_SEQ, NPC_HOLD:                                  res = 1'b0;
         default:                                            res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pc_seq_unit_ras.sv
// Circular return-address stack: write pointer plus saturating count.
// Pushing when full overwrites the oldest entry; popping when empty leaves
// pointer/count alone and raises a sticky underflow flag.
module ras_stack #(
   parameter int               WIDTH     = 16,
   parameter int               RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0] RESET_PC  = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             replace,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full,
   output logic             underflow
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_r [RAS_DEPTH];
   logic [PW-1:0]    wptr_r;
   logic [CW-1:0]    count_r;
   logic             underflow_r;
   logic [PW-1:0]    top_idx_s;
   logic             empty_s;
   logic             full_s;

   // Derived status and the index of the most recently pushed entry.
   always_comb begin
      top_idx_s = wptr_r - PW'(1);
      empty_s   = (count_r == CW'(0));
      full_s    = (count_r == CW'(RAS_DEPTH));
   end

   // Stack storage, pointer, count and sticky underflow; replace on an empty stack acts as a push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_r       <= '{default: {WIDTH{1'b0}}};
         wptr_r      <= {PW{1'b0}};
         count_r     <= {CW{1'b0}};
         underflow_r <= 1'b0;
      end else if (push || (replace && empty_s)) begin
         mem_r[wptr_r] <= data;
         wptr_r        <= wptr_r + PW'(1);
         if (!full_s) begin
            count_r <= count_r + CW'(1);
         end
      end else if (replace) begin
         mem_r[top_idx_s] <= data;
      end else if (pop) begin
         if (empty_s) begin
            underflow_r <= 1'b1;
         end else begin
            wptr_r  <= wptr_r - PW'(1);
            count_r <= count_r - CW'(1);
         end
      end
   end

   assign top       = empty_s ? RESET_PC : mem_r[top_idx_s];
   assign empty     = empty_s;
   assign full      = full_s;
   assign underflow = underflow_r;

endmodule

// File: rtl/pc_seq_unit.sv
// Next-PC sequencer: PC register, jump-target formation and the fixed
// priority encoder (redirect > stall > ret > call > jmp > sequential).
module pc_seq_unit
   import pc_seq_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               RAS_DEPTH = DEF_RAS_DEPTH,
   parameter int               JMP_BITS  = DEF_JMP_BITS,
   parameter logic [WIDTH-1:0] RESET_PC  = {WIDTH{1'b0}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [WIDTH-1:0]    redirect_pc,
   input  logic [WIDTH-1:0]    id_pc,
   input  logic                jmp,
   input  logic                call,
   input  logic                ret,
   input  logic [JMP_BITS-1:0] jmp_imm,
   output logic [WIDTH-1:0]    pc,
   output logic                flush_id,
   output logic [WIDTH-1:0]    ras_top,
   output logic                ras_empty,
   output logic                ras_full,
   output logic                ras_underflow
);

   logic [WIDTH-1:0] pc_r;
   logic [WIDTH-1:0] id_pc_inc_s;
   logic [WIDTH-1:0] target_s;
   logic [WIDTH-1:0] next_pc_s;
   logic [WIDTH-1:0] ras_top_s;
   npc_sel_e         sel_s;

   // Jump target keeps the upper bits of the return address and splices in the immediate.
   always_comb begin
      id_pc_inc_s = id_pc + WIDTH'(1);
      target_s    = {id_pc_inc_s[WIDTH-1:JMP_BITS], jmp_imm};
   end

   // Fixed-priority selection of the next-PC source.
   always_comb begin
      if (redirect_valid) begin
         sel_s = NPC_REDIR;
      end else if (stall) begin
         sel_s = NPC_HOLD;
      end else if (ret && call) begin
         sel_s = NPC_CALLRET;
      end else if (ret) begin
         sel_s = NPC_RET;
      end else if (call) begin
         sel_s = NPC_CALL;
      end else if (jmp) begin
         sel_s = NPC_JMP;
      end else begin
         sel_s = NPC_SEQ;
      end
   end

   // Next-PC mux driven by the selected source.
   always_comb begin
      case (sel_s)
         NPC_REDIR:   next_pc_s = redirect_pc;
         NPC_HOLD:    next_pc_s = pc_r;
         NPC_RET:     next_pc_s = ras_top_s;
         NPC_CALL:    next_pc_s = target_s;
         NPC_CALLRET: next_pc_s = target_s;
         NPC_JMP:     next_pc_s = target_s;
         NPC_SEQ:     next_pc_s = pc_r + WIDTH'(1);
         default:     next_pc_s = pc_r + WIDTH'(1);
      endcase
   end

   // Program counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= next_pc_s;
      end
   end

   ras_stack #(
      .WIDTH     (WIDTH),
      .RAS_DEPTH (RAS_DEPTH),
      .RESET_PC  (RESET_PC)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (sel_s == NPC_CALL),
      .pop       (sel_s == NPC_RET),
      .replace   (sel_s == NPC_CALLRET),
      .data      (id_pc_inc_s),
      .top       (ras_top_s),
      .empty     (ras_empty),
      .full      (ras_full),
      .underflow (ras_underflow)
   );

   assign pc       = pc_r;
   assign ras_top  = ras_top_s;
   assign flush_id = !rst && sel_flushes(sel_s);

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised next-PC sequencer for the pipelined core, the successor to the single-cycle PC/RR path. It owns the program counter, resolves redirects from execute and jumps, calls and returns from decode under a fixed priority, and handles fetch stalls. A multi-entry circular return-address stack (RAS) replaces the single return register. The block sits between the hazard unit, the decode/execute stages and instruction fetch.

## Interface
- WIDTH, 16, PC and address width
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2)
- JMP_BITS, 9, width of the direct-jump immediate
- RESET_PC, 0, PC value after reset and on an empty-stack pop

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard stall; PC holds and decode controls are ignored
- redirect_valid  in  1  execute-stage redirect (taken branch / for-loop)
- redirect_pc  in  WIDTH  redirect target
- id_pc  in  WIDTH  PC of the instruction in decode
- jmp  in  1  decode: direct jump
- call  in  1  decode: direct jump plus push of id_pc+1
- ret  in  1  decode: jump to popped RAS entry
- jmp_imm  in  JMP_BITS  jump immediate
- pc  out  WIDTH  current fetch PC (registered)
- flush_id  out  1  squash the instruction currently in fetch/decode
- ras_top  out  WIDTH  current top-of-stack value (RESET_PC when empty)
- ras_empty  out  1  stack count = 0
- ras_full  out  1  stack count = RAS_DEPTH
- ras_underflow  out  1  sticky; set by a pop on an empty stack

## Operation
- Jump target = {(id_pc+1)[WIDTH-1:JMP_BITS], jmp_imm}.
- All additions are modulo 2^WIDTH. 0xFFFF+1 wraps to 0x0000.
- Next-PC priority, highest first:
  - redirect_valid → redirect_pc. All decode controls are ignored; no push or pop.
  - stall → pc holds. Decode controls are ignored.
  - ret (with or without jmp) → pop the RAS; next pc = popped value.
  - call (with or without jmp) → push id_pc+1; next pc = jump target.
  - jmp → jump target.
  - otherwise → pc+1.
- call and ret together: next pc = jump target. The top entry is overwritten with id_pc+1; count is unchanged. When the stack is empty, this is a plain push.
- flush_id = 1 in the same cycle that a redirect, jmp, call or ret is accepted; otherwise 0.
- RAS behaviour:
  - Circular buffer with a write pointer and a count saturating at RAS_DEPTH.
  - Push when full: the oldest entry is overwritten; ras_full stays 1.
  - Pop when empty: returns RESET_PC, sets ras_underflow, pointer and count are unchanged.
  - ras_underflow clears only on rst.
- Reset values: pc = RESET_PC, count = 0, all entries = 0, ras_underflow = 0, ras_empty = 1, ras_full = 0. flush_id = 0 while rst is asserted.

## Timing
- pc, RAS entries, pointer, count and ras_underflow are registered on the rising edge of clk.
- rst clears them immediately (asynchronously). Operation resumes at the first clk edge after rst deasserts.
- Next-PC selection and flush_id are combinational from inputs in the same cycle.
- Latency: a redirect, jump, call or ret accepted in cycle N appears on pc in cycle N+1.
- ras_top, ras_empty and ras_full reflect post-update state in cycle N+1.
- A push and the following ret in consecutive cycles must return the just-pushed value (no bypass needed; the value is registered).
- rst asserted mid-redirect or mid-stall: the reset state wins; no partial push or pop survives.

## Structure
- Package pc_seq_pkg:
  - next-PC select enum: NPC_SEQ, NPC_HOLD, NPC_REDIR, NPC_JMP, NPC_CALL, NPC_RET, NPC_CALLRET
  - default parameter constants
- Sub-module ras_stack (parameters WIDTH and RAS_DEPTH):
  - inputs: push, pop, replace, data
  - outputs: top, empty, full, underflow
- The top level holds the PC register, target formation and the priority encoder.

## Test plan
- Reset mid-run: rst asserted at pc = 0x0005 → pc = 0x0000 before the next edge; ras_empty = 1, ras_underflow = 0.
- Sequential and stall: free-run gives 0,1,2,3. Stall for 2 cycles → pc holds 0x0003 with flush_id = 0, then continues with 0x0004.
- Call/return: id_pc = 0x0210, call, jmp_imm = 0x045 → pc = 0x0245, ras_top = 0x0211, flush_id = 1. A later ret → pc = 0x0211, ras_empty = 1.
- Priority: redirect_valid = 1 (redirect_pc = 0x0080) together with call and stall → pc = 0x0080, no push, flush_id = 1.
- Overflow/underflow, RAS_DEPTH = 4:
  - Five calls pushing 0x11, 0x22, 0x33, 0x44, 0x55 → ras_full = 1.
  - Four rets return 0x55, 0x44, 0x33, 0x22.
  - A fifth ret → pc = 0x0000 and ras_underflow = 1 (sticky).
- call+ret together with the stack holding 0x0100 and id_pc = 0x0300 → pc = jump target, ras_top = 0x0301, count unchanged.
